// File: rtl/test_cam_top_if.sv
// Camera, VGA and frame-buffer observation signals of the capture block.
// The master side is the capture block itself; the slave side is the board/environment.
interface test_cam_top_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 12
);
  logic          CAM_PCLK;
  logic          CAM_HREF;
  logic          CAM_VSYNC;
  logic [7:0]    CAM_px_data;
  logic          CAM_xclk;
  logic          CAM_pwdn;
  logic          CAM_reset;
  logic          VGA_Hsync_n;
  logic          VGA_Vsync_n;
  logic [3:0]    VGA_R;
  logic [3:0]    VGA_G;
  logic [3:0]    VGA_B;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          DP_RAM_we;       // buffer write strobe, exposed for observation
  logic [AW-1:0] DP_RAM_addr_out;
  logic [DW-1:0] data_mem;

  modport master (
    input  CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_px_data,
    output CAM_xclk, CAM_pwdn, CAM_reset,
    output VGA_Hsync_n, VGA_Vsync_n, VGA_R, VGA_G, VGA_B,
    output DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_we, DP_RAM_addr_out, data_mem
  );

  modport slave (
    output CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_px_data,
    input  CAM_xclk, CAM_pwdn, CAM_reset,
    input  VGA_Hsync_n, VGA_Vsync_n, VGA_R, VGA_G, VGA_B,
    input  DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_we, DP_RAM_addr_out, data_mem
  );
endinterface

// File: rtl/test_cam_top.sv
// Camera-to-VGA capture: samples an 8-bit RGB444 camera bus into a dual-port
// frame buffer and scans it out as 640x480 VGA with the picture top-left.
module test_cam_top #(
  parameter int unsigned IMG_W = 160,
  parameter int unsigned IMG_H = 120,
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 12
) (
  input  logic           clk,
  input  logic           rst,
  test_cam_top_if.master bus
);

  localparam int unsigned   Depth    = IMG_W * IMG_H;
  localparam int unsigned   IdxW     = $clog2(Depth);
  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);
  localparam logic [AW-1:0] ImgWA    = AW'(IMG_W);
  localparam logic [9:0]    ImgW10   = 10'(IMG_W);
  localparam logic [9:0]    ImgH10   = 10'(IMG_H);
  localparam logic [9:0]    HLast    = 10'd799;
  localparam logic [9:0]    VLast    = 10'd524;
  localparam logic [9:0]    HsBeg    = 10'd656;
  localparam logic [9:0]    HsEnd    = 10'd751;
  localparam logic [9:0]    VsBeg    = 10'd490;
  localparam logic [9:0]    VsEnd    = 10'd491;

  typedef enum logic {StFirst, StSecond} phase_e;

  // ---------------------------------------------------------------------------
  // Pixel clock enable and camera master clock
  logic [1:0] div_q;
  logic       pix_en;

  assign pix_en        = (div_q == 2'd3);
  assign bus.CAM_xclk  = div_q[1];
  assign bus.CAM_pwdn  = 1'b0;
  assign bus.CAM_reset = 1'b1;

  // Free-running divide-by-four counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= 2'd0;
    else     div_q <= div_q + 2'd1;
  end

  // ---------------------------------------------------------------------------
  // Camera bus synchronizer; PCLK is treated as data and edge-detected.
  logic       pclk_s1_q, pclk_s2_q, pclk_prev_q;
  logic       href_s1_q, href_s2_q;
  logic       vsync_s1_q, vsync_s2_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic       pclk_rise;

  assign pclk_rise = pclk_s2_q & ~pclk_prev_q;

  // Two-flop synchronizer plus previous-PCLK register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1_q   <= 1'b0;
      pclk_s2_q   <= 1'b0;
      pclk_prev_q <= 1'b0;
      href_s1_q   <= 1'b0;
      href_s2_q   <= 1'b0;
      vsync_s1_q  <= 1'b0;
      vsync_s2_q  <= 1'b0;
      data_s1_q   <= 8'd0;
      data_s2_q   <= 8'd0;
    end else begin
      pclk_s1_q   <= bus.CAM_PCLK;
      pclk_s2_q   <= pclk_s1_q;
      pclk_prev_q <= pclk_s2_q;
      href_s1_q   <= bus.CAM_HREF;
      href_s2_q   <= href_s1_q;
      vsync_s1_q  <= bus.CAM_VSYNC;
      vsync_s2_q  <= vsync_s1_q;
      data_s1_q   <= bus.CAM_px_data;
      data_s2_q   <= data_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-pair assembly and write-address generation
  phase_e        phase_q, phase_d;
  logic [3:0]    red_q, red_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          full_q, full_d;  // last buffer word written; hold off until VSYNC

  // Capture state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= StFirst;
      red_q   <= 4'd0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      red_q   <= red_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      full_q  <= full_d;
    end
  end

  // Next-state: advance the address after each write, then act on a PCLK edge.
  always_comb begin
    phase_d = phase_q;
    red_d   = red_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    full_d  = full_q;

    if (we_q) begin
      if (waddr_q == LastAddr) full_d  = 1'b1;
      else                     waddr_d = waddr_q + AW'(1);
    end

    if (pclk_rise) begin
      if (vsync_s2_q) begin
        waddr_d = '0;
        phase_d = StFirst;
        full_d  = 1'b0;
      end else if (href_s2_q) begin
        unique case (phase_q)
          StFirst: begin
            red_d   = data_s2_q[3:0];
            phase_d = StSecond;
          end
          StSecond: begin
            phase_d = StFirst;
            wdata_d = DW'({red_q, data_s2_q});
            we_d    = ~full_q;
          end
          default: phase_d = StFirst;
        endcase
      end else begin
        phase_d = StFirst;
      end
    end
  end

  assign bus.DP_RAM_addr_in = waddr_q;
  assign bus.DP_RAM_data_in = wdata_q;
  assign bus.DP_RAM_we      = we_q;

  // ---------------------------------------------------------------------------
  // Frame buffer
  logic [DW-1:0] mem [Depth];
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_q;

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_q) mem[waddr_q[IdxW-1:0]] <= wdata_q;
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr[IdxW-1:0]];
  end

  assign bus.data_mem = rdata_q;

  // ---------------------------------------------------------------------------
  // VGA scan
  logic [9:0]    h_q, v_q;
  logic          in_img;
  logic          hs_n_q, vs_n_q;
  logic [DW-1:0] rgb_q;

  assign in_img              = (h_q < ImgW10) && (v_q < ImgH10);
  assign raddr               = in_img ? (AW'(v_q) * ImgWA + AW'(h_q)) : '0;
  assign bus.DP_RAM_addr_out = raddr;

  // Scan counters and pixel-aligned output registers; outputs lag h/v by one pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q    <= 10'd0;
      v_q    <= 10'd0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      rgb_q  <= '0;
    end else if (pix_en) begin
      hs_n_q <= ~((h_q >= HsBeg) && (h_q <= HsEnd));
      vs_n_q <= ~((v_q >= VsBeg) && (v_q <= VsEnd));
      rgb_q  <= in_img ? rdata_q : '0;
      if (h_q == HLast) begin
        h_q <= 10'd0;
        v_q <= (v_q == VLast) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_q <= h_q + 10'd1;
      end
    end
  end

  assign bus.VGA_Hsync_n = hs_n_q;
  assign bus.VGA_Vsync_n = vs_n_q;
  assign bus.VGA_R       = rgb_q[11:8];
  assign bus.VGA_G       = rgb_q[7:4];
  assign bus.VGA_B       = rgb_q[3:0];

endmodule

// File: tb/tb_test_cam_top.sv
// Bench for test_cam_top: directed camera stimulus, a behavioural model of the
// capture/scan behaviour, and per-cycle comparison. A reduced image height
// keeps a full captured frame and the readback scan short.
module tb_test_cam_top;

  localparam int unsigned IMG_W = 160;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned N     = IMG_W * IMG_H;
  localparam int          QMAX  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  test_cam_top_if bus ();

  test_cam_top #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (15),
    .DW    (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected-write list, filled by the stimulus driver, consumed by the checker.
  int          exp_cyc [QMAX];
  int          exp_a   [QMAX];
  logic [11:0] exp_d   [QMAX];
  int          wr_head = 0;

  // Camera-side model state (driver owned).
  int         cap_addr = 0;
  bit         cap_ph   = 0;
  bit         cap_full = 0;
  logic [3:0] cap_r    = 4'd0;

  // Scan/buffer model state (checker owned).
  int          cyc      = 0;
  int          m_n      = 0;
  bit          rst_prev = 1'b1;
  logic        m_hs     = 1'b1;
  logic        m_vs     = 1'b1;
  logic [11:0] m_rgb    = '0;
  bit          m_rgb_ok = 1'b1;
  logic [11:0] m_dm     = '0;
  bit          m_dm_ok  = 1'b1;
  logic [11:0] shadow    [N];
  bit          shadow_ok [N];
  bit          pend   = 1'b0;
  int          pend_a = 0;
  logic [11:0] pend_d = '0;
  int          rd_ptr = 0;
  int          wcnt   = 0;
  int          last_wa = -1;
  int          last_wd = -1;
  int          hs_lo  = 0;

  function automatic bit img_at(input int p);
    int h, v;
    h = p % 800;
    v = (p / 800) % 525;
    return (h < IMG_W) && (v < IMG_H);
  endfunction

  function automatic int addr_at(input int p);
    int h, v;
    h = p % 800;
    v = (p / 800) % 525;
    return img_at(p) ? v * IMG_W + h : 0;
  endfunction

  int          t_p, t_a, t_h, t_v;
  logic [11:0] t_old;
  bit          t_old_ok, t_ew;

  // Model step for the edge just passed, then compare every DUT output.
  always @(negedge clk) begin
    cyc++;
    if (rst || rst_prev) begin
      m_n = 0; m_hs = 1'b1; m_vs = 1'b1; m_rgb = '0; m_rgb_ok = 1'b1;
      m_dm = '0; m_dm_ok = 1'b1; pend = 1'b0; rd_ptr = wr_head; hs_lo = 0;
    end else begin
      t_p = m_n / 4;
      t_a = addr_at(t_p);
      t_old = m_dm;
      t_old_ok = m_dm_ok;
      m_dm = shadow[t_a];
      m_dm_ok = shadow_ok[t_a];
      if (m_n % 4 == 3) begin
        t_h = t_p % 800;
        t_v = (t_p / 800) % 525;
        m_hs = !(t_h >= 656 && t_h <= 751);
        m_vs = !(t_v >= 490 && t_v <= 491);
        m_rgb = img_at(t_p) ? t_old : 12'h000;
        m_rgb_ok = img_at(t_p) ? t_old_ok : 1'b1;
      end
      if (pend) begin
        shadow[pend_a] = pend_d;
        shadow_ok[pend_a] = 1'b1;
        pend = 1'b0;
      end
      m_n++;
    end
    rst_prev = rst;

    chk("xclk", int'(bus.CAM_xclk), int'((m_n % 4) >= 2));
    chk("pwdn", int'(bus.CAM_pwdn), 0);
    chk("cam_reset", int'(bus.CAM_reset), 1);
    chk("hsync_n", int'(bus.VGA_Hsync_n), int'(m_hs));
    chk("vsync_n", int'(bus.VGA_Vsync_n), int'(m_vs));
    chk("addr_out", int'(bus.DP_RAM_addr_out), addr_at(m_n / 4));
    if (m_dm_ok) chk("data_mem", int'(bus.data_mem), int'(m_dm));
    if (m_rgb_ok) chk("rgb", int'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), int'(m_rgb));

    if (rst) begin
      chk("we_rst", int'(bus.DP_RAM_we), 0);
      chk("addr_in_rst", int'(bus.DP_RAM_addr_in), 0);
      chk("data_in_rst", int'(bus.DP_RAM_data_in), 0);
    end else begin
      t_ew = (rd_ptr < wr_head) && (exp_cyc[rd_ptr] == cyc);
      chk("we_strobe", int'(bus.DP_RAM_we), int'(t_ew));
      if (t_ew) begin
        chk("wr_addr", int'(bus.DP_RAM_addr_in), exp_a[rd_ptr]);
        chk("wr_data", int'(bus.DP_RAM_data_in), int'(exp_d[rd_ptr]));
        pend = 1'b1;
        pend_a = exp_a[rd_ptr];
        pend_d = exp_d[rd_ptr];
        rd_ptr++;
      end
    end
    if (bus.DP_RAM_we) begin
      wcnt++;
      last_wa = int'(bus.DP_RAM_addr_in);
      last_wd = int'(bus.DP_RAM_data_in);
    end
    if (!bus.VGA_Hsync_n) hs_lo++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One camera byte: set up, raise PCLK after 2 clk, hold 2 clk; model the edge.
  task automatic send_byte(input logic [7:0] b, input logic hr, input logic vs);
    bus.CAM_PCLK = 1'b0;
    bus.CAM_HREF = hr;
    bus.CAM_VSYNC = vs;
    bus.CAM_px_data = b;
    tick();
    tick();
    bus.CAM_PCLK = 1'b1;
    if (vs) begin
      cap_addr = 0; cap_ph = 0; cap_full = 0;
    end else if (hr && !cap_ph) begin
      cap_r = b[3:0]; cap_ph = 1;
    end else if (hr) begin
      cap_ph = 0;
      if (!cap_full) begin
        exp_cyc[wr_head] = cyc + 4;
        exp_a[wr_head] = cap_addr;
        exp_d[wr_head] = {cap_r, b};
        wr_head++;
        if (cap_addr == N - 1) cap_full = 1;
        else cap_addr++;
      end
    end else begin
      cap_ph = 0;
    end
    tick();
    tick();
  endtask

  task automatic send_blank(input int n, input logic vs);
    for (int i = 0; i < n; i++) send_byte(8'h00, 1'b0, vs);
  endtask

  task automatic send_pixels(input int line, input int x0, input int x1, input int kind);
    logic [7:0] b0, b1;
    for (int x = x0; x < x1; x++) begin
      case (kind)
        0: begin b0 = 8'h0F; b1 = 8'hA5; end
        1: begin b0 = 8'hF0; b1 = 8'hF0; end
        default: begin
          if (line == 2 && x == 5) begin b0 = 8'h01; b1 = 8'h23; end
          else begin b0 = 8'(x); b1 = 8'(x * 3 + line); end
        end
      endcase
      send_byte(b0, 1'b1, 1'b0);
      send_byte(b1, 1'b1, 1'b0);
    end
  endtask

  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (m_n != target && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (m_n != target) chk("scan_timeout", m_n, target);
  endtask

  int w0;

  initial begin
    bus.CAM_PCLK = 1'b0;
    bus.CAM_HREF = 1'b0;
    bus.CAM_VSYNC = 1'b0;
    bus.CAM_px_data = 8'h00;
    rst = 1'b1;
    repeat (20) tick();
    chk("rst_hsync", int'(bus.VGA_Hsync_n), 1);
    chk("rst_vsync", int'(bus.VGA_Vsync_n), 1);
    chk("rst_rgb", int'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 0);
    chk("rst_data_mem", int'(bus.data_mem), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("xclk_toggle", int'(bus.CAM_xclk), (i / 2) % 2);
      tick();
    end

    // One line of 0x0F/0xA5 pairs.
    w0 = wcnt;
    send_blank(2, 1'b1);
    send_blank(2, 1'b0);
    send_pixels(0, 0, IMG_W, 0);
    send_blank(4, 1'b0);
    chk("line_count", wcnt - w0, 160);
    chk("line_last_addr", last_wa, 159);
    chk("line_last_data", last_wd, 'hFA5);

    // Full frame of 0xF0.
    w0 = wcnt;
    send_blank(4, 1'b1);
    send_blank(4, 1'b0);
    for (int l = 0; l < IMG_H; l++) begin
      send_pixels(l, 0, IMG_W, 1);
      send_blank(4, 1'b0);
    end
    chk("frame_count", wcnt - w0, N);
    chk("frame_last_addr", last_wa, N - 1);
    chk("frame_last_data", last_wd, 'h0F0);

    // A further line after the buffer is full writes nothing.
    w0 = wcnt;
    send_pixels(0, 0, IMG_W, 1);
    send_blank(4, 1'b0);
    chk("sat_no_write", wcnt - w0, 0);

    // Next VSYNC restarts at address 0; this frame carries pixel (5,2)=0x123.
    send_blank(4, 1'b1);
    send_blank(4, 1'b0);
    w0 = wcnt;
    send_pixels(0, 0, 1, 2);
    tick();
    tick();
    chk("vsync_restart_cnt", wcnt - w0, 1);
    chk("vsync_restart_addr", last_wa, 0);
    send_pixels(0, 1, IMG_W, 2);
    send_blank(4, 1'b0);
    for (int l = 1; l < 3; l++) begin
      send_pixels(l, 0, IMG_W, 2);
      send_blank(4, 1'b0);
    end

    // Reset in the middle of a line, after the first byte of a pixel.
    send_pixels(3, 0, 10, 2);
    send_byte(8'h77, 1'b1, 1'b0);
    chk("midline_addr_before", last_wa, 3 * IMG_W + 9);
    bus.CAM_PCLK = 1'b0;
    tick();
    rst = 1'b1;
    cap_addr = 0; cap_ph = 0; cap_full = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    w0 = wcnt;
    send_pixels(3, 0, 1, 2);
    tick();
    tick();
    chk("midline_rst_cnt", wcnt - w0, 1);
    chk("midline_rst_addr", last_wa, 0);
    send_blank(4, 1'b0);

    // Readback: restart the scan and watch pixel (5,2).
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    wait_n(4 * 1605 + 1);
    chk("readback_addr_out", int'(bus.DP_RAM_addr_out), 325);
    wait_n(4 * 1606 + 1);
    chk("readback_R", int'(bus.VGA_R), 1);
    chk("readback_G", int'(bus.VGA_G), 2);
    chk("readback_B", int'(bus.VGA_B), 3);
    chk("hsync_low_two_lines", hs_lo, 2 * 96 * 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
